instr_fetch: RTL and testbench

Instruction fetch sequencer for the distributed processor core. Owns the instruction pointer, issues reads to the synchronous command memory, holds the fetched command word and presents its opcode to the control decoder. It computes the next pointer from the decoder's instruction-pointer load enable and the ALU condition bit.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: instruction-pointer load encodings, fetch state enum, opcode field width.
// Used by the fetch sequencer and the control decoder so both agree on the encodings.
package instr_fetch_pkg;

  localparam int OPCODE_W = 8;

  localparam logic [1:0] LD_SEQ      = 2'b00;
  localparam logic [1:0] LD_JUMP     = 2'b01;
  localparam logic [1:0] LD_ALU_JUMP = 2'b10;
  localparam logic [1:0] LD_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Illegal encoding falls back to sequential, so only these two cases redirect.
  function automatic logic take_jump(input logic [1:0] load_en, input logic alu_cond);
    return (load_en == LD_JUMP) || ((load_en == LD_ALU_JUMP) && alu_cond);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: one strobe per fetch, word captured MEM_LATENCY cycles later, held until advance.
// Throughput one instruction per MEM_LATENCY+2 cycles; without advance the word is held indefinitely; stop aborts.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int CMD_WIDTH   = 128,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [CMD_WIDTH-1:0]  mem_data,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic [OPCODE_W-1:0]   opcode,
  output logic                  cmd_valid,
  input  logic                  advance,
  input  logic [1:0]            instr_ptr_load_en,
  input  logic                  alu_cond,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  illegal_load
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

  fetch_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  illegal_q, illegal_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    rd_en_d     = 1'b0;
    illegal_d   = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
          rd_en_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // Aborting here drops whatever read is still in the memory pipeline.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cmd_d       = mem_data;
          cmd_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
        end else if (advance) begin
          pc_d        = take_jump(instr_ptr_load_en, alu_cond) ? jump_addr : pc_q + 1'b1;
          illegal_d   = illegal_q | (instr_ptr_load_en == LD_ILLEGAL);
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          rd_en_d     = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pc_q        <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
    end
  end

  // The address register is the pc itself, so it is stable for the whole fetch.
  assign mem_addr     = pc_q;
  assign mem_rd_en    = rd_en_q;
  assign cmd_out      = cmd_q;
  assign opcode       = cmd_q[CMD_WIDTH-1 -: OPCODE_W];
  assign cmd_valid    = cmd_valid_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign illegal_load = illegal_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-accurate memory, transaction-level reference model, directed and random phases.
module tb_instr_fetch;

  localparam int CW = 128;
  localparam int AW = 8;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, stop = 1'b0, advance = 1'b0, alu_cond = 1'b0;
  logic [1:0]    load_en = 2'b00;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] mem_addr, pc;
  logic          mem_rd_en, cmd_valid, busy, illegal_load;
  logic [CW-1:0] mem_data, cmd_out;
  logic [7:0]    opcode;

  instr_fetch #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .cmd_out(cmd_out), .opcode(opcode), .cmd_valid(cmd_valid), .advance(advance),
    .instr_ptr_load_en(load_en), .alu_cond(alu_cond), .jump_addr(jump_addr),
    .pc(pc), .busy(busy), .illegal_load(illegal_load)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Memory image: top byte of word i is i^A5 so opcodes can be predicted by hand.
  logic [CW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i) ^ 8'hA5, 24'(i), $urandom(), $urandom(), $urandom()};
  end

  // Synchronous memory: data for a strobe appears ML cycles later; garbage otherwise.
  logic [CW-1:0] pipe [ML];
  always @(posedge clk) begin
    for (int i = ML - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_rd_en ? mem[mem_addr] : {$urandom(), $urandom(), $urandom(), $urandom()};
  end
  assign mem_data = pipe[ML-1];

  // Reference model: running/holding flags, pc, and cycles elapsed since the fetch strobe.
  bit            m_active = 0;
  bit            m_valid = 0;
  bit            m_illegal = 0;
  int            m_pc = 0;
  int            m_age = -1;
  logic [CW-1:0] m_word = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 0; m_valid = 0; m_illegal = 0; m_pc = 0; m_age = -1; m_word = '0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1; m_pc = 0; m_age = 0;
      end
    end else if (stop) begin
      m_active = 0; m_valid = 0; m_age = -1;
    end else if (m_age >= 0) begin
      if (m_age == ML) begin
        m_valid = 1; m_word = mem[m_pc]; m_age = -1;
      end else begin
        m_age++;
      end
    end else if (advance) begin
      if (load_en == 2'b01 || (load_en == 2'b10 && alu_cond)) m_pc = int'(jump_addr);
      else m_pc = (m_pc + 1) % 256;
      if (load_en == 2'b11) m_illegal = 1;
      m_valid = 0;
      m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", CW'(busy), CW'(m_active));
      chk("cmd_valid", CW'(cmd_valid), CW'(m_valid));
      chk("mem_rd_en", CW'(mem_rd_en), CW'(m_active && m_age == 0));
      chk("pc", CW'(pc), CW'(m_pc));
      chk("illegal_load", CW'(illegal_load), CW'(m_illegal));
      if (m_active && m_age >= 0) chk("mem_addr", CW'(mem_addr), CW'(m_pc));
      if (m_valid) begin
        chk("cmd_out", cmd_out, m_word);
        chk("opcode", CW'(opcode), CW'(m_word[CW-1 -: 8]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 20 && !cmd_valid; i++) step();
    chk(nm, CW'(cmd_valid), CW'(1));
  endtask

  task automatic do_advance(input logic [1:0] le, input logic cond, input logic [AW-1:0] ja);
    advance = 1; load_en = le; alu_cond = cond; jump_addr = ja;
    step();
    advance = 0; load_en = 2'b00; alu_cond = 0; jump_addr = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_pc", CW'(pc), CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_cmd_out", cmd_out, CW'(0));
    chk("rst_rd_en", CW'(mem_rd_en), CW'(0));
    chk_en = 1'b1;

    // First fetch timing.
    start = 1; step(); start = 0;
    chk("t1_rd_en", CW'(mem_rd_en), CW'(1));
    chk("t1_addr", CW'(mem_addr), CW'(0));
    step(); chk("t2_rd_en", CW'(mem_rd_en), CW'(0));
    step(); chk("t3_valid", CW'(cmd_valid), CW'(0));
    step(); chk("t4_valid", CW'(cmd_valid), CW'(1));
    chk("t4_word", cmd_out, mem[0]);
    chk("t4_opcode", CW'(opcode), CW'(8'hA5));

    do_advance(2'b00, 0, 8'h33);
    chk("seq_addr", CW'(mem_addr), CW'(8'h01));
    chk("seq_valid_drop", CW'(cmd_valid), CW'(0));
    wait_valid("wv_seq"); chk("op_1", CW'(opcode), CW'(8'hA4));

    do_advance(2'b01, 0, 8'h40);
    chk("jmp_addr", CW'(mem_addr), CW'(8'h40));
    wait_valid("wv_jmp"); chk("op_40", CW'(opcode), CW'(8'hE5));

    do_advance(2'b10, 0, 8'h80);
    chk("alu0_addr", CW'(mem_addr), CW'(8'h41));
    wait_valid("wv_alu0"); chk("op_41", CW'(opcode), CW'(8'hE4));

    do_advance(2'b10, 1, 8'hFF);
    chk("alu1_addr", CW'(mem_addr), CW'(8'hFF));
    wait_valid("wv_alu1"); chk("op_ff", CW'(opcode), CW'(8'h5A));

    do_advance(2'b00, 0, 8'h12);
    chk("wrap_addr", CW'(mem_addr), CW'(8'h00));
    chk("wrap_no_err", CW'(illegal_load), CW'(0));
    wait_valid("wv_wrap"); chk("op_00", CW'(opcode), CW'(8'hA5));

    do_advance(2'b11, 1, 8'h77);
    chk("ill_addr", CW'(mem_addr), CW'(8'h01));
    chk("ill_flag", CW'(illegal_load), CW'(1));
    wait_valid("wv_ill");

    // Stall in HOLD: word stable, no new reads.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_word", cmd_out, mem[1]);
      chk("hold_no_rd", CW'(mem_rd_en), CW'(0));
    end

    // Abort one cycle after the strobe; the late read must never surface.
    do_advance(2'b00, 0, 8'h00);
    chk("abort_rd_en", CW'(mem_rd_en), CW'(1));
    step();
    stop = 1; step(); stop = 0;
    chk("abort_busy", CW'(busy), CW'(0));
    chk("abort_pc", CW'(pc), CW'(8'h02));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", CW'(cmd_valid), CW'(0));
    end

    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("startstop_idle", CW'(busy), CW'(0));
    chk("startstop_no_rd", CW'(mem_rd_en), CW'(0));

    start = 1; step(); start = 0;
    chk("restart_rd", CW'(mem_rd_en), CW'(1));
    chk("restart_addr", CW'(mem_addr), CW'(0));
    wait_valid("wv_restart");
    chk("restart_word", cmd_out, mem[0]);
    chk("ill_sticky", CW'(illegal_load), CW'(1));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      advance   = stop ? 1'b0 : 1'($urandom_range(0, 1));
      load_en   = 2'($urandom_range(0, 3));
      alu_cond  = 1'($urandom_range(0, 1));
      jump_addr = 8'($urandom_range(0, 255));
      step();
    end
    start = 0; stop = 0; advance = 0; load_en = 0; alu_cond = 0; jump_addr = 0;

    // Force a known illegal, then reset mid-fetch.
    stop = 1; step(); stop = 0;
    start = 1; step(); start = 0;
    wait_valid("wv_pre_rst");
    do_advance(2'b11, 0, 8'h00);
    chk("pre_rst_ill", CW'(illegal_load), CW'(1));
    step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", CW'(busy), CW'(0));
    chk("arst_pc", CW'(pc), CW'(0));
    chk("arst_addr", CW'(mem_addr), CW'(0));
    chk("arst_rd_en", CW'(mem_rd_en), CW'(0));
    chk("arst_cmd", cmd_out, CW'(0));
    chk("arst_opcode", CW'(opcode), CW'(0));
    chk("arst_valid", CW'(cmd_valid), CW'(0));
    chk("arst_ill", CW'(illegal_load), CW'(0));
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
